piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in serial-out transmitter; the sending end of the serial link whose receiving end is sipo.
//   Captures a WIDTH-bit word on a load handshake and frames it onto one serial line:
//   start bit, data bits LSB-first, optional even parity bit, stop bit.
//   Sits between switch/adder logic and the sipo input; idle line level is high.
// PARAMETERS
//   WIDTH         3   data bits per frame (matches sipo parallel width); legal range >=1
//   CLKS_PER_BIT  4   clk cycles each serial bit is held; legal range >=1
//   PARITY_EN     1   1 = append even-parity bit after data; 0 = no parity bit
// PORTS
//   clk      in   1      system clock, all state updates on posedge
//   btn_clr  in   1      asynchronous active-high reset
//   din      in   WIDTH  parallel word to send; sampled only on an accepted load
//   load     in   1      request to send din; accepted when load=1 and ready=1 at posedge clk
//   ready    out  1      1 = IDLE, a load will be accepted this cycle
//   busy     out  1      1 = a frame is in progress (START..STOP)
//   so       out  1      serial data out, idle high
//   done     out  1      one-cycle pulse when a frame completes
// BEHAVIOUR
//   Reset (btn_clr=1, asynchronous): so=1, ready=1, busy=0, done=0, state=IDLE,
//     bit counter=0, cycle counter=0, shift register=0.
//   Reset applies immediately, even mid-frame: the frame is aborted, so returns to 1, and done does not pulse.
//   FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
//   IDLE: so=1, ready=1, busy=0.
//     On an accepted load, capture din into the shift register and compute parity = ^din.
//     Go to START; so=0 from the next cycle.
//   START: so=0 for CLKS_PER_BIT cycles, then DATA.
//   DATA: so = shreg[0]. Each bit is held CLKS_PER_BIT cycles, then shreg shifts right.
//     After WIDTH bits, go to PARITY, or to STOP if PARITY_EN=0.
//   PARITY: so = ^din, captured at load time (even parity), held CLKS_PER_BIT cycles.
//   STOP: so=1 for CLKS_PER_BIT cycles, then IDLE.
//   done=1 for exactly the first IDLE cycle after STOP; ready=1 in that same cycle.
//   Frame length: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles, counted from the first start-bit cycle.
//   Back-to-back: a load accepted in the done cycle starts the next frame.
//     This leaves exactly one idle-high cycle between a stop bit and the next start bit.
//   load while busy: ignored; din is not sampled and the current frame is unaffected.
//   din changing after acceptance: no effect on the frame in flight.
//   All outputs are registered; there are no combinational paths from inputs to outputs.
//   Counters are sized to hold CLKS_PER_BIT-1 and WIDTH-1 and never wrap mid-bit.
// TESTING (WIDTH=3, CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
//   1. Assert btn_clr for 3 cycles
//      -> so=1, ready=1, busy=0, done=0 throughout and after release.
//   2. din=3'b101, load pulsed 1 cycle
//      -> so = 0,1,0,1,0,1, each held 4 cycles (24 cycles total).
//      -> busy=1 for those 24 cycles; done=1 for 1 cycle immediately after.
//   3. din=3'b111, load 1 cycle -> so = 0,1,1,1,1,1 (parity=1).
//      Repeat with PARITY_EN=0 -> so = 0,1,1,1,1, frame is 20 cycles.
//   4. din=3'b001 accepted; during DATA, load=1 with din=3'b010
//      -> ignored, ready stays 0, so sequence is 0,1,0,0,1,1.
//   5. load held high continuously, din=3'b110
//      -> frames repeat every 25 cycles, with one idle-high cycle between each stop and start.
//      -> done pulses once per frame.
//   6. btn_clr pulsed during the second data bit
//      -> so=1 and busy=0 the same cycle, no done pulse.
//      -> A following load of 3'b011 transmits a clean frame 0,1,1,0,0,1.

Source files
------------

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle between a word source and the piso_tx framer.
// The master drives the word and load request, and the slave reports status and the serial line.
interface piso_tx_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             busy;
  logic             so;
  logic             done;

  modport master (output din, load, input ready, busy, so, done);
  modport slave  (input din, load, output ready, busy, so, done);
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out framer: start bit, LSB-first data, optional even parity, stop bit.
// The line idles high. Every output comes from a register loaded from next-state values.
module piso_tx #(
  parameter int WIDTH        = 3,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic      clk,
  input  logic      btn_clr,
  piso_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [2:0]       state_r, state_s;
  logic [CW-1:0]    cyc_r, cyc_s;
  logic [BW-1:0]    bit_r, bit_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic             par_r, par_s;
  logic             so_r, so_s;
  logic             ready_r, busy_r, done_r, done_s;
  logic             bit_end_s;

  assign bit_end_s = (cyc_r == CYC_LAST);

  // Next-state, counter and shift-register update
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    par_s   = par_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.load) begin
          state_s = ST_START;
          shreg_s = bus.din;
          par_s   = even_parity(bus.din);
          cyc_s   = '0;
          bit_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cyc_s   = '0;
          state_s = ST_DATA;
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cyc_s   = '0;
          shreg_s = shreg_r >> 1;
          if (bit_r == BIT_LAST) begin
            bit_s   = '0;
            state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_s = bit_r + BW'(1);
          end
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          cyc_s   = '0;
          state_s = ST_STOP;
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cyc_s   = '0;
          state_s = ST_IDLE;
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = '0;
        bit_s   = '0;
      end
    endcase
  end

  // Line level the registered output will carry once the next state is entered
  always_comb begin
    so_s = 1'b1;
    case (state_s)
      ST_IDLE:   so_s = 1'b1;
      ST_START:  so_s = 1'b0;
      ST_DATA:   so_s = shreg_s[0];
      ST_PARITY: so_s = par_s;
      ST_STOP:   so_s = 1'b1;
      default:   so_s = 1'b1;
    endcase
    done_s = (state_r == ST_STOP) && (state_s == ST_IDLE);
  end

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk or posedge btn_clr) begin
    if (btn_clr) begin
      state_r <= ST_IDLE;
      cyc_r   <= '0;
      bit_r   <= '0;
      shreg_r <= '0;
      par_r   <= 1'b0;
      so_r    <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
      par_r   <= par_s;
      so_r    <= so_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
    end
  end

  assign bus.so    = so_r;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx: one parity-enabled and one parity-less instance
// sharing clock and reset, with the serial line compared against hand-computed frames.
module tb_piso_tx;

  localparam int W   = 3;
  localparam int CPB = 4;

  logic clk;
  logic btn_clr;
  int   checks;
  int   errors;

  logic [127:0] so_v, busy_v, done_v, ready_v, nso_v, nbusy_v, ndone_v;
  logic [127:0] exp_v;

  piso_tx_if #(.WIDTH(W)) bus ();
  piso_tx_if #(.WIDTH(W)) bus_np ();

  piso_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .btn_clr(btn_clr), .bus(bus)
  );

  piso_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
    .clk(clk), .btn_clr(btn_clr), .bus(bus_np)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] expand(input logic [7:0] bits, input int nb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < CPB; j++)
        r[i*CPB+j] = bits[i];
    return r;
  endfunction

  task automatic record(input int n);
    so_v = '0; busy_v = '0; done_v = '0; ready_v = '0;
    nso_v = '0; nbusy_v = '0; ndone_v = '0;
    for (int i = 0; i < n; i++) begin
      so_v[i]    = bus.so;
      busy_v[i]  = bus.busy;
      done_v[i]  = bus.done;
      ready_v[i] = bus.ready;
      nso_v[i]   = bus_np.so;
      nbusy_v[i] = bus_np.busy;
      ndone_v[i] = bus_np.done;
      @(negedge clk);
    end
  endtask

  // Pulses load for one cycle; returns at the negedge showing the first start-bit cycle.
  task automatic load_word(input logic [2:0] w, input bit np);
    @(negedge clk);
    if (np) begin
      bus_np.din  = w;
      bus_np.load = 1'b1;
    end else begin
      bus.din  = w;
      bus.load = 1'b1;
    end
    @(negedge clk);
    bus.load    = 1'b0;
    bus_np.load = 1'b0;
  endtask

  task automatic test_reset();
    btn_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.so, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got so/ready/busy/done=%b expected 1100", i,
                 {bus.so, bus.ready, bus.busy, bus.done});
      end
    end
    btn_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.so, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: got %b expected 1100", {bus.so, bus.ready, bus.busy, bus.done});
    end
    checks++;
    if ({bus_np.so, bus_np.ready, bus_np.busy, bus_np.done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release_np: got %b expected 1100",
               {bus_np.so, bus_np.ready, bus_np.busy, bus_np.done});
    end
  endtask

  task automatic test_frame();
    load_word(3'b101, 1'b0);
    record(26);
    exp_v = expand(8'b0010_1010, 6);
    checks++;
    if (so_v[23:0] !== exp_v[23:0]) begin
      errors++;
      $display("FAIL frame_so: got %h expected %h", so_v[23:0], exp_v[23:0]);
    end
    checks++;
    if (busy_v[23:0] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL frame_busy: got %h expected ffffff", busy_v[23:0]);
    end
    checks++;
    if (ready_v[23:0] !== 24'h000000 || done_v[23:0] !== 24'h000000) begin
      errors++;
      $display("FAIL frame_ready_done: got ready=%h done=%h expected 000000", ready_v[23:0], done_v[23:0]);
    end
    checks++;
    if ({so_v[24], ready_v[24], busy_v[24], done_v[24]} !== 4'b1101) begin
      errors++;
      $display("FAIL frame_end: got so/ready/busy/done=%b expected 1101",
               {so_v[24], ready_v[24], busy_v[24], done_v[24]});
    end
    checks++;
    if (done_v[25] !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: got done=%b expected 0", done_v[25]);
    end
  endtask

  task automatic test_parity();
    load_word(3'b111, 1'b0);
    record(25);
    exp_v = expand(8'b0011_1110, 6);
    checks++;
    if (so_v[23:0] !== exp_v[23:0] || done_v[24] !== 1'b1) begin
      errors++;
      $display("FAIL parity_so: got %h done=%b expected %h done=1", so_v[23:0], done_v[24], exp_v[23:0]);
    end
    load_word(3'b111, 1'b1);
    record(21);
    exp_v = expand(8'b0001_1110, 5);
    checks++;
    if (nso_v[19:0] !== exp_v[19:0]) begin
      errors++;
      $display("FAIL noparity_so: got %h expected %h", nso_v[19:0], exp_v[19:0]);
    end
    checks++;
    if (nbusy_v[19:0] !== 20'hFFFFF || nbusy_v[20] !== 1'b0 || ndone_v[20] !== 1'b1) begin
      errors++;
      $display("FAIL noparity_len: got busy=%h busy20=%b done20=%b expected fffff 0 1",
               nbusy_v[19:0], nbusy_v[20], ndone_v[20]);
    end
  endtask

  task automatic test_load_while_busy();
    load_word(3'b001, 1'b0);
    so_v = '0; ready_v = '0; done_v = '0;
    for (int i = 0; i < 25; i++) begin
      so_v[i]    = bus.so;
      ready_v[i] = bus.ready;
      done_v[i]  = bus.done;
      if (i == 6) begin
        bus.din  = 3'b010;
        bus.load = 1'b1;
      end else if (i == 10) begin
        bus.din  = 3'b000;
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    exp_v = expand(8'b0011_0010, 6);
    checks++;
    if (so_v[23:0] !== exp_v[23:0]) begin
      errors++;
      $display("FAIL busy_load_so: got %h expected %h", so_v[23:0], exp_v[23:0]);
    end
    checks++;
    if (ready_v[23:0] !== 24'h000000 || done_v[24] !== 1'b1) begin
      errors++;
      $display("FAIL busy_load_ready: got ready=%h done24=%b expected 000000 1", ready_v[23:0], done_v[24]);
    end
    record(4);
    checks++;
    if (busy_v[3:0] !== 4'b0000 || so_v[3:0] !== 4'b1111) begin
      errors++;
      $display("FAIL busy_load_idle: got busy=%b so=%b expected 0000 1111", busy_v[3:0], so_v[3:0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.din  = 3'b110;
    bus.load = 1'b1;
    @(negedge clk);
    so_v = '0; done_v = '0;
    for (int i = 0; i < 75; i++) begin
      so_v[i]   = bus.so;
      done_v[i] = bus.done;
      if (i == 74) bus.load = 1'b0;
      @(negedge clk);
    end
    exp_v = '0;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 24; b++) exp_v[f*25+b] = (b / CPB == 2 || b / CPB == 3 || b / CPB == 5);
      exp_v[f*25+24] = 1'b1;
    end
    checks++;
    if (so_v[74:0] !== exp_v[74:0]) begin
      errors++;
      $display("FAIL b2b_so: got %h expected %h", so_v[74:0], exp_v[74:0]);
    end
    checks++;
    if ($countones(done_v[74:0]) != 3 || done_v[24] !== 1'b1 || done_v[49] !== 1'b1 || done_v[74] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %h expected pulses at 24,49,74", done_v[74:0]);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.so !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b so=%b expected 0 1", bus.busy, bus.so);
    end
  endtask

  task automatic test_reset_mid_frame();
    load_word(3'b101, 1'b0);
    repeat (9) @(negedge clk);
    btn_clr = 1'b1;
    #1;
    checks++;
    if ({bus.so, bus.ready, bus.busy, bus.done} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_now: got so/ready/busy/done=%b expected 1100",
               {bus.so, bus.ready, bus.busy, bus.done});
    end
    @(negedge clk);
    btn_clr = 1'b0;
    record(6);
    checks++;
    if (done_v[5:0] !== 6'b000000 || busy_v[5:0] !== 6'b000000) begin
      errors++;
      $display("FAIL midreset_quiet: got done=%b busy=%b expected 000000", done_v[5:0], busy_v[5:0]);
    end
    load_word(3'b011, 1'b0);
    record(25);
    exp_v = expand(8'b0010_0110, 6);
    checks++;
    if (so_v[23:0] !== exp_v[23:0] || done_v[24] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clean: got %h done=%b expected %h done=1", so_v[23:0], done_v[24], exp_v[23:0]);
    end
  endtask

  initial begin
    clk = 1'b0;
    btn_clr = 1'b1;
    checks = 0;
    errors = 0;
    bus.din = '0;
    bus.load = 1'b0;
    bus_np.din = '0;
    bus_np.load = 1'b0;
    test_reset();
    test_frame();
    test_parity();
    test_load_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
